// File: rtl/decoder_defs.sv
// Shared definitions for the decoder family.
//   clog2       : constant function, ceil(log2(n)); returns 0 for n <= 1
//   POL_HIGH/LOW: output polarity selectors for the ACTIVE_LOW parameter
//   MODE_DIRECT/MODE_SCAN : encodings of the mode input
package decoder_defs;

  localparam int POL_HIGH = 0;
  localparam int POL_LOW  = 1;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2(input longint n);
    int r;
    r = 0;
    for (longint v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/v_decoder_core.sv
// Combinational index -> one-hot decoder.
//   idx_i    : index to decode (SEL_W bits)
//   onehot_o : 2**SEL_W wide; bit idx_i at the active level, all others
//              inactive. ACTIVE_LOW = POL_LOW inverts the whole vector.
module v_decoder_core
  import decoder_defs::*;
#(
  parameter int SEL_W      = 3,
  parameter int ACTIVE_LOW = POL_HIGH
) (
  input  logic [SEL_W-1:0]        idx_i,
  output logic [(1<<SEL_W)-1:0]   onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
    if (ACTIVE_LOW == POL_LOW) begin
      onehot_o = ~onehot_o;
    end
  end

endmodule

// File: rtl/v_decoder_scan.sv
// Registered one-hot decoder with a built-in scan sequencer.
//   clk, rst : clock, synchronous active-high reset
//   mode     : 0 = direct (idx holds), 1 = scan (idx advances every DWELL
//              enabled cycles)
//   load/sel : load sel into the index register (honoured even with en=0)
//   en       : 1 = run and drive res; 0 = freeze counters and blank res
//   res      : registered decode of the index (polarity from ACTIVE_LOW)
//   idx      : current index register
//   step     : one-cycle pulse when the sequencer advanced idx
//   wrap     : one-cycle pulse when that advance went from OUT_W-1 to 0
// Edge priority: rst > load > scan advance > hold.
module v_decoder_scan
  import decoder_defs::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = POL_HIGH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic                    load,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    en,
  output logic [(1<<SEL_W)-1:0]   res,
  output logic [SEL_W-1:0]        idx,
  output logic                    step,
  output logic                    wrap
);

  localparam int OUT_W  = 1 << SEL_W;
  // Dwell counter is at least one bit wide so DWELL=1 still has a register.
  localparam int DCNT_W = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  IDX_LAST  = SEL_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0]  RES_IDLE  = (ACTIVE_LOW == POL_LOW) ? '1 : '0;

  logic [SEL_W-1:0]  idx_q,  idx_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic [OUT_W-1:0]  res_q,  res_d;
  logic [OUT_W-1:0]  dec_next;

  // Decode the next index so res shows the new value in the same cycle
  // that idx (and step/wrap) report it.
  v_decoder_core #(
    .SEL_W      (SEL_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_core (
    .idx_i    (idx_d),
    .onehot_o (dec_next)
  );

  always_comb begin
    idx_d  = idx_q;
    dcnt_d = dcnt_q;
    step_d = 1'b0;
    wrap_d = 1'b0;

    if (load) begin
      idx_d  = sel;
      dcnt_d = '0;
    end else if (mode == MODE_SCAN) begin
      if (en) begin
        if (dcnt_q == DCNT_LAST) begin
          idx_d  = idx_q + SEL_W'(1);   // natural modulo-OUT_W wrap
          dcnt_d = '0;
          step_d = 1'b1;
          wrap_d = (idx_q == IDX_LAST);
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
    end else begin
      // Direct mode keeps the dwell counter cleared so a later switch to
      // scan gives a full first dwell.
      dcnt_d = '0;
    end

    res_d = en ? dec_next : RES_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      dcnt_q <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      res_q  <= RES_IDLE;
    end else begin
      idx_q  <= idx_d;
      dcnt_q <= dcnt_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      res_q  <= res_d;
    end
  end

  assign res  = res_q;
  assign idx  = idx_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_v_decoder_scan.sv
// Bench for v_decoder_scan. Instance A: SEL_W=3, DWELL=4, active-high.
// Instance B: SEL_W=2, DWELL=1, active-low.
module tb_v_decoder_scan;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, mode_a, load_a, en_a;
  logic [2:0] sel_a;
  logic [7:0] res_a;
  logic [2:0] idx_a;
  logic       step_a, wrap_a;

  logic       rst_b, mode_b, load_b, en_b;
  logic [1:0] sel_b;
  logic [3:0] res_b;
  logic [1:0] idx_b;
  logic       step_b, wrap_b;

  int vectors     = 0;
  int miscompares = 0;

  v_decoder_scan #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst_a), .mode(mode_a), .load(load_a), .sel(sel_a),
    .en(en_a), .res(res_a), .idx(idx_a), .step(step_a), .wrap(wrap_a)
  );

  v_decoder_scan #(.SEL_W(2), .DWELL(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst_b), .mode(mode_b), .load(load_b), .sel(sel_b),
    .en(en_b), .res(res_b), .idx(idx_b), .step(step_b), .wrap(wrap_b)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Tracks which index is shown and how many enabled cycles it has been
  // shown for; an index moves on once it has been shown for DWELL cycles.
  typedef struct {
    int         idx;
    int         cnt;
    logic       step;
    logic       wrap;
    logic [7:0] res;
  } m_state_t;

  m_state_t ma, mb;

  task automatic model_step(input int sel_w, input int dwell, input int al,
                            input logic r, input logic m, input logic l,
                            input logic e, input int s, inout m_state_t st);
    int         out_w;
    logic [7:0] mask, hot;
    out_w   = 1 << sel_w;
    mask    = 8'((1 << out_w) - 1);
    st.step = 1'b0;
    st.wrap = 1'b0;
    if (r) begin
      st.idx = 0;
      st.cnt = 0;
    end else if (l) begin
      st.idx = s;
      st.cnt = 0;
    end else if (m) begin
      if (e) begin
        if (st.cnt + 1 >= dwell) begin
          st.step = 1'b1;
          st.wrap = (st.idx == out_w - 1);
          st.idx  = (st.idx + 1) % out_w;
          st.cnt  = 0;
        end else begin
          st.cnt = st.cnt + 1;
        end
      end
    end else begin
      st.cnt = 0;
    end
    hot = 8'(1 << st.idx);
    if (r || !e) st.res = (al != 0) ? mask : 8'h00;
    else         st.res = (al != 0) ? (~hot & mask) : hot;
  endtask

  function automatic logic [13:0] got_a();
    return {res_a, idx_a, step_a, wrap_a};
  endfunction
  function automatic logic [13:0] exp_a();
    return {ma.res, 3'(ma.idx), ma.step, ma.wrap};
  endfunction
  function automatic logic [7:0] got_b();
    return {res_b, idx_b, step_b, wrap_b};
  endfunction
  function automatic logic [7:0] exp_b();
    return {ma.res[3:0] ^ ma.res[3:0] ^ mb.res[3:0], 2'(mb.idx), mb.step, mb.wrap};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: advance both models with the inputs the DUTs sample, then
  // move 1 time unit past the edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    model_step(3, 4, 0, rst_a, mode_a, load_a, en_a, int'(sel_a), ma);
    model_step(2, 1, 1, rst_b, mode_b, load_b, en_b, int'(sel_b), mb);
    #1;
  endtask

  task automatic do_reset(input logic m);
    rst_a = 1'b1; mode_a = m; load_a = 1'b0; en_a = 1'b1; sel_a = '0;
    rst_b = 1'b1; mode_b = m; load_b = 1'b0; en_b = 1'b1; sel_b = '0;
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_a = 1'b1; mode_a = 1'b1; load_a = 1'b1; sel_a = 3'd5; en_a = 1'b1;
    rst_b = 1'b1; mode_b = 1'b1; load_b = 1'b1; sel_b = 2'd3; en_b = 1'b1;
    tick();
    vectors++;
    if (got_a() !== {8'h00, 3'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_a: got %h expected %h", got_a(), {8'h00, 3'd0, 2'b00});
    end
    vectors++;
    if (got_b() !== {4'hF, 2'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_b: got %h expected %h", got_b(), {4'hF, 2'd0, 2'b00});
    end
    rst_a = 1'b0; load_a = 1'b0;
    rst_b = 1'b0; load_b = 1'b0;
  endtask

  task automatic test_direct_load();
    do_reset(1'b0);
    load_a = 1'b1; sel_a = 3'd5;
    tick();
    load_a = 1'b0; sel_a = 3'd1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got_a() !== {8'h20, 3'd5, 2'b00}) begin
        miscompares++;
        $display("FAIL direct_load cyc=%0d: got %h expected %h", i, got_a(), {8'h20, 3'd5, 2'b00});
      end
      tick();
    end
  endtask

  task automatic test_scan_rotation();
    int wraps;
    logic [13:0] want;
    wraps = 0;
    do_reset(1'b1);
    for (int k = 1; k <= 64; k++) begin
      tick();
      want = {8'(1 << ((k / 4) % 8)), 3'((k / 4) % 8), (k % 4 == 0), (k % 32 == 0)};
      if (wrap_a) wraps++;
      vectors++;
      if (got_a() !== want) begin
        miscompares++;
        $display("FAIL scan_rotation k=%0d: got %h expected %h", k, got_a(), want);
      end
    end
    vectors++;
    if (wraps != 2) begin
      miscompares++;
      $display("FAIL scan_wrap_count: got %0d expected 2", wraps);
    end
  endtask

  task automatic test_enable_freeze();
    do_reset(1'b1);
    for (int k = 0; k < 14; k++) tick();   // idx=3, dwell count 2
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (got_a() !== {8'h00, 3'd3, 2'b00}) begin
        miscompares++;
        $display("FAIL freeze cyc=%0d: got %h expected %h", i, got_a(), {8'h00, 3'd3, 2'b00});
      end
    end
    en_a = 1'b1;
    tick();
    vectors++;
    if (got_a() !== {8'h08, 3'd3, 2'b00}) begin
      miscompares++;
      $display("FAIL unfreeze_hold: got %h expected %h", got_a(), {8'h08, 3'd3, 2'b00});
    end
    tick();
    vectors++;
    if (got_a() !== {8'h10, 3'd4, 2'b10}) begin
      miscompares++;
      $display("FAIL unfreeze_step: got %h expected %h", got_a(), {8'h10, 3'd4, 2'b10});
    end
  endtask

  task automatic test_load_collision();
    do_reset(1'b1);
    for (int k = 0; k < 31; k++) tick();   // idx=7, dwell count 3
    load_a = 1'b1; sel_a = 3'd2;
    tick();
    load_a = 1'b0;
    vectors++;
    if (got_a() !== {8'h04, 3'd2, 2'b00}) begin
      miscompares++;
      $display("FAIL collision_load: got %h expected %h", got_a(), {8'h04, 3'd2, 2'b00});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (got_a() !== {8'h04, 3'd2, 2'b00}) begin
        miscompares++;
        $display("FAIL collision_dwell cyc=%0d: got %h expected %h", i, got_a(), {8'h04, 3'd2, 2'b00});
      end
    end
    tick();
    vectors++;
    if (got_a() !== {8'h08, 3'd3, 2'b10}) begin
      miscompares++;
      $display("FAIL collision_next: got %h expected %h", got_a(), {8'h08, 3'd3, 2'b10});
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset(1'b1);
    for (int k = 0; k < 25; k++) tick();   // idx=6, mid-dwell
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    vectors++;
    if (got_a() !== {8'h00, 3'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL midscan_reset: got %h expected %h", got_a(), {8'h00, 3'd0, 2'b00});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (got_a() !== {8'h01, 3'd0, 2'b00}) begin
        miscompares++;
        $display("FAIL midscan_hold cyc=%0d: got %h expected %h", i, got_a(), {8'h01, 3'd0, 2'b00});
      end
    end
    tick();
    vectors++;
    if (got_a() !== {8'h02, 3'd1, 2'b10}) begin
      miscompares++;
      $display("FAIL midscan_step: got %h expected %h", got_a(), {8'h02, 3'd1, 2'b10});
    end
  endtask

  task automatic test_active_low();
    logic [7:0] want;
    do_reset(1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      want = {~(4'(1 << (k % 4))), 2'(k % 4), 1'b1, (k % 4 == 0)};
      vectors++;
      if (got_b() !== want) begin
        miscompares++;
        $display("FAIL active_low k=%0d: got %h expected %h", k, got_b(), want);
      end
    end
    en_b = 1'b0;
    tick();
    vectors++;
    if (got_b() !== {4'hF, 2'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL active_low_blank: got %h expected %h", got_b(), {4'hF, 2'd0, 2'b00});
    end
    en_b = 1'b1;
  endtask

  task automatic test_random();
    do_reset(1'b1);
    for (int i = 0; i < 400; i++) begin
      rst_a  = ($urandom_range(0, 31) == 0);
      load_a = ($urandom_range(0, 5) == 0);
      sel_a  = 3'($urandom_range(0, 7));
      mode_a = ($urandom_range(0, 9) < 8);
      en_a   = ($urandom_range(0, 19) < 17);
      rst_b  = ($urandom_range(0, 31) == 0);
      load_b = ($urandom_range(0, 5) == 0);
      sel_b  = 2'($urandom_range(0, 3));
      mode_b = ($urandom_range(0, 9) < 8);
      en_b   = ($urandom_range(0, 19) < 17);
      tick();
      vectors++;
      if (got_a() !== exp_a()) begin
        miscompares++;
        $display("FAIL random_a i=%0d: got %h expected %h", i, got_a(), exp_a());
      end
      vectors++;
      if (got_b() !== exp_b()) begin
        miscompares++;
        $display("FAIL random_b i=%0d: got %h expected %h", i, got_b(), exp_b());
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_a = 1'b1; mode_a = 1'b0; load_a = 1'b0; en_a = 1'b0; sel_a = '0;
    rst_b = 1'b1; mode_b = 1'b0; load_b = 1'b0; en_b = 1'b0; sel_b = '0;
    @(negedge clk);
    test_reset();
    test_direct_load();
    test_scan_rotation();
    test_enable_freeze();
    test_load_collision();
    test_reset_mid_scan();
    test_active_low();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/v_decoder_scan.md
# v_decoder_scan

Parametrised, registered 1-of-2^SEL_W one-hot decoder with a built-in scan sequencer. In direct mode it latches a loaded index and drives the matching one-hot line. In scan mode it walks the active line through every output, holding each for DWELL cycles. It sits between control logic and multiplexed drivers such as LED digit strobes, keypad row drives and bank selects, and replaces the fixed 3-to-8 combinational decoder wherever a registered, enable-gated or auto-scanning select is needed.

## Interface
Parameters:
- SEL_W, 3, index width; output width OUT_W = 2**SEL_W (derived localparam, not overridable)
- DWELL, 4, cycles each index is held in scan mode; legal range 1..65536
- ACTIVE_LOW, 0, 0 = selected line is 1 and others 0; 1 = selected line is 0 and others 1

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = direct, 1 = scan
- load  in  1  when 1, the index register takes sel at the next edge (both modes)
- sel  in  SEL_W  index to load
- en  in  1  1 = run and drive outputs; 0 = freeze counters and blank res
- res  out  OUT_W  registered decoded output
- idx  out  SEL_W  current index register
- step  out  1  one-cycle pulse: index advanced by the scan sequencer
- wrap  out  1  one-cycle pulse: scan advance from OUT_W-1 to 0

## Operation
- State: idx register (SEL_W bits); dwell counter dcnt, width clog2(DWELL), minimum 1 bit.
- Reset (rst=1 at an edge): idx=0, dcnt=0, step=0, wrap=0, res = inactive pattern (all 0, or all 1 if ACTIVE_LOW). rst overrides every other input.
- Priority per edge: rst > load > scan advance > hold.
- load=1: idx <= sel and dcnt <= 0. No step or wrap pulse. load is honoured even when en=0.
- Direct mode (mode=0, load=0): idx holds; dcnt is forced to 0.
- Scan mode (mode=1, load=0, en=1):
  - If dcnt == DWELL-1: idx <= idx+1 modulo OUT_W (natural wrap), dcnt <= 0, step <= 1.
  - Also wrap <= 1 when the old idx was OUT_W-1.
  - Otherwise dcnt <= dcnt+1.
- en=0 and load=0: idx and dcnt hold, step=0, wrap=0.
- Mode switch from 0 to 1: dcnt is already 0, so the first advance occurs DWELL enabled cycles later. Mode switch from 1 to 0: dcnt clears at the next edge and idx holds its value.
- Output at each edge:
  - res <= decode(idx_next) when en=1, else the inactive pattern.
  - decode(i) sets exactly bit i to the active level.
  - With ACTIVE_LOW=1, the whole vector is inverted.
- Exactly one bit of res is active whenever en was 1 at the last edge and rst was 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Load latency: load and sel sampled at edge k; idx and res reflect sel after edge k (1 cycle).
- Enable latency: en sampled at edge k takes effect on res after edge k (blanking and unblanking are both 1 cycle).
- Scan period: each index is active for DWELL enabled cycles. A full rotation takes OUT_W*DWELL enabled cycles.
- step and wrap assert in the same cycle that res first shows the new index, for exactly one cycle.
- DWELL=1: idx advances at every enabled edge, and step stays high continuously.
- load coinciding with a scan advance: load wins, with no step or wrap pulse. Dwell restarts at the loaded index.
- rst asserted mid-dwell: all state clears at that edge. After release, in scan mode, index 0 is held for a full DWELL cycles.

## Structure
- Shared include/package file `decoder_defs`:
  - constant function clog2
  - polarity constants POL_HIGH=0 and POL_LOW=1
  - mode constants MODE_DIRECT=0 and MODE_SCAN=1
- Sub-module `v_decoder_core`: purely combinational, parameterised by SEL_W and ACTIVE_LOW, mapping index to OUT_W one-hot. It is reused by later decoder variants.
- Top level contains the idx and dcnt registers, the priority logic, and the registered res, step and wrap.

## Test plan
- Reset then direct load: SEL_W=3, mode=0, en=1, load sel=5 -> one cycle later res=8'b00100000 and idx=5. Holds indefinitely, step=0.
- Scan rotation: SEL_W=3, DWELL=4, mode=1 from reset -> res steps 0x01,0x02,...,0x80,0x01, each held 4 cycles. step pulses every 4 cycles. wrap pulses once per 32 cycles, with res=0x01.
- Enable freeze: scan running at idx=3 with dcnt=2, en=0 for 10 cycles -> res=0x00, no pulses. After en=1, idx=3 is held for 1 more cycle before advancing to 4.
- Load versus advance collision: DWELL=4, idx=7, dcnt=3, load sel=2 at the same edge -> idx=2, res=0x04, step=0, wrap=0. The next advance comes 4 cycles later.
- Active-low with DWELL=1: ACTIVE_LOW=1, SEL_W=2, mode=1 -> res cycles 4'b1110,1101,1011,0111 every cycle. step stays constant 1. en=0 gives res=4'b1111.
- Reset mid-scan: rst pulsed at idx=6 -> next cycle res=inactive pattern, idx=0, step=0, wrap=0. After release, index 0 is held for DWELL cycles.
